ysyx_041514_alu_div_ctrl: RTL

Sequencing controller between the EXU and the multi-cycle slow divider. Decodes RV64M DIV/DIVU/REM/REMU and their W forms. Returns the RISC-V special cases (divide-by-zero, signed overflow) without starting the divider. Keeps a one-entry result cache so a DIV followed by a REM on the same operands costs one cycle. Owns the valid/ready handshake, flush handling and W-result sign extension.

---
 rtl/ysyx_041514_div_pkg.sv | 17 +
 rtl/ysyx_041514_div_special.sv | 30 +++
 rtl/ysyx_041514_alu_div_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_041514_div_pkg.sv
// Shared definitions for the divider sequencing controller: op-bit layout and FSM states.
package ysyx_041514_div_pkg;

  localparam int unsigned OP_REM      = 0;
  localparam int unsigned OP_UNSIGNED = 1;
  localparam int unsigned OP_WORD     = 2;

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StIdle  = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StResp  = 3'd4,
    StDrain = 3'd5
  } div_state_e;

endpackage

// File: rtl/ysyx_041514_div_special.sv
// RISC-V division special cases (divide-by-zero, signed overflow) resolved without the divider.
module ysyx_041514_div_special
  import ysyx_041514_div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      op_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] spec_quot_o,
  output logic [XLEN-1:0] spec_rem_o
);

  logic word, div_zero, min_neg, neg_one, overflow;

  always_comb begin
    word     = op_i[OP_WORD];
    div_zero = word ? (rs2_i[31:0] == 32'd0) : (rs2_i == '0);
    min_neg  = word ? (rs1_i[31:0] == 32'h8000_0000) : (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
    neg_one  = word ? (rs2_i[31:0] == 32'hFFFF_FFFF) : (rs2_i == '1);
    overflow = ~op_i[OP_UNSIGNED] & min_neg & neg_one & ~div_zero;

    is_special_o = div_zero | overflow;
    // W sign extension happens downstream, so the full-width dividend is passed through here.
    spec_quot_o  = div_zero ? '1 : rs1_i;
    spec_rem_o   = div_zero ? rs1_i : '0;
  end

endmodule

// File: rtl/ysyx_041514_alu_div_ctrl.sv
// EXU-side sequencer for the slow divider: special cases, one-entry result cache,
// valid/ready handshakes, flush draining and W-result sign extension.
module ysyx_041514_alu_div_ctrl
  import ysyx_041514_div_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  input  logic            flush_i,
  output logic            div_valid_o,
  output logic            div_signed_o,
  output logic            div32_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic [XLEN-1:0] div_quot_i,
  input  logic [XLEN-1:0] div_rem_i,
  input  logic            div_ready_i
);

  div_state_e      state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q;

  logic            cache_vld_q, cache_uns_q, cache_word_q;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q, cache_quot_q, cache_rem_q;

  logic            is_special, cache_hit;
  logic [XLEN-1:0] spec_quot, spec_rem;

  function automatic logic [XLEN-1:0] fmt_result(input logic [2:0]      op,
                                                  input logic [XLEN-1:0] quot,
                                                  input logic [XLEN-1:0] rem);
    logic [XLEN-1:0] sel;
    sel = op[OP_REM] ? rem : quot;
    if (op[OP_WORD]) return {{(XLEN-32){sel[31]}}, sel[31:0]};
    return sel;
  endfunction

  // Evaluated on the incoming request so a special case or hit responds the next cycle.
  ysyx_041514_div_special #(
    .XLEN (XLEN)
  ) u_special (
    .rs1_i        (req_rs1_i),
    .rs2_i        (req_rs2_i),
    .op_i         (req_op_i),
    .is_special_o (is_special),
    .spec_quot_o  (spec_quot),
    .spec_rem_o   (spec_rem)
  );

  always_comb begin
    cache_hit = CACHE_EN && cache_vld_q &&
                (req_rs1_i == cache_rs1_q) && (req_rs2_i == cache_rs2_q) &&
                (req_op_i[OP_UNSIGNED] == cache_uns_q) && (req_op_i[OP_WORD] == cache_word_q);
  end

  // Divider operands come straight from the latched request so they stay put through DRAIN.
  assign div_dividend_o = rs1_q;
  assign div_divisor_o  = rs2_q;
  assign div_signed_o   = ~op_q[OP_UNSIGNED];
  assign div32_o        = op_q[OP_WORD];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBoot;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      div_valid_o  <= 1'b0;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      cache_vld_q  <= 1'b0;
      cache_uns_q  <= 1'b0;
      cache_word_q <= 1'b0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_quot_q <= '0;
      cache_rem_q  <= '0;
    end else begin
      div_valid_o <= 1'b0;
      if (flush_i) cache_vld_q <= 1'b0;

      unique case (state_q)
        StBoot: begin
          state_q     <= StIdle;
          req_ready_o <= 1'b1;
        end
        StIdle: begin
          if (req_valid_i && !flush_i) begin
            op_q        <= req_op_i;
            rs1_q       <= req_rs1_i;
            rs2_q       <= req_rs2_i;
            req_ready_o <= 1'b0;
            if (is_special) begin
              resp_data_o  <= fmt_result(req_op_i, spec_quot, spec_rem);
              resp_valid_o <= 1'b1;
              state_q      <= StResp;
            end else if (cache_hit) begin
              resp_data_o  <= fmt_result(req_op_i, cache_quot_q, cache_rem_q);
              resp_valid_o <= 1'b1;
              state_q      <= StResp;
            end else begin
              div_valid_o <= 1'b1;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          state_q <= flush_i ? StDrain : StWait;
        end
        StWait: begin
          if (flush_i) begin
            // A result arriving with the flush is simply discarded.
            if (div_ready_i) begin
              state_q     <= StIdle;
              req_ready_o <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else if (div_ready_i) begin
            cache_vld_q  <= CACHE_EN;
            cache_uns_q  <= op_q[OP_UNSIGNED];
            cache_word_q <= op_q[OP_WORD];
            cache_rs1_q  <= rs1_q;
            cache_rs2_q  <= rs2_q;
            cache_quot_q <= div_quot_i;
            cache_rem_q  <= div_rem_i;
            resp_data_o  <= fmt_result(op_q, div_quot_i, div_rem_i);
            resp_valid_o <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (flush_i || resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        StDrain: begin
          if (div_ready_i) begin
            req_ready_o <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StBoot;
          req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
